// File: rtl/id_ex_skid.sv
// Elastic ID/EX pipeline register: a main entry driving the execute stage plus one
// skid entry, valid/ready handshake, synchronous flush and a saturating stall counter.
module id_ex_skid #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rdata1,
  input  logic [DATA_W-1:0] in_rdata2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_alusrc,
  input  logic [4:0]        in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rdata1,
  output logic [DATA_W-1:0] out_rdata2,
  output logic [DATA_W-1:0] out_imm,
  output logic              out_alusrc,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic              alusrc;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  entry_t           in_entry;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             in_fire, out_fire;

  // Handshake is decoded from state alone, so out_ready never reaches in_ready.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  assign in_entry = '{rdata1: in_rdata1, rdata2: in_rdata2, imm: in_imm,
                      alusrc: in_alusrc, rd: in_rd, ctrl: in_ctrl};

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_entry;
        end else if (in_fire) begin
          skid_d  = in_entry;
          state_d = TWO;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Squash wins over every transition; stale payload is hidden by out_valid = 0.
    if (flush) begin
      state_d = EMPTY;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_rdata1 = main_q.rdata1;
  assign out_rdata2 = main_q.rdata2;
  assign out_imm    = main_q.imm;
  assign out_alusrc = main_q.alusrc;
  assign out_rd     = main_q.rd;
  assign out_ctrl   = main_q.ctrl;
  assign stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: a two-deep queue model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_id_ex_skid;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic              alusrc;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_rdata1 = '0;
  logic [DATA_W-1:0] in_rdata2 = '0;
  logic [DATA_W-1:0] in_imm = '0;
  logic              in_alusrc = 1'b0;
  logic [4:0]        in_rd = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_rdata1, out_rdata2, out_imm;
  logic              out_alusrc;
  logic [4:0]        out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int tests = 0;
  int fails = 0;

  ent_t m_q[$];
  int   m_cnt = 0;
  int   log_rd[$];

  id_ex_skid #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2), .in_imm(in_imm),
    .in_alusrc(in_alusrc), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rdata1(out_rdata1), .out_rdata2(out_rdata2), .out_imm(out_imm),
    .out_alusrc(out_alusrc), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a FIFO of capacity two; stalls counted whenever something is waiting.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_cnt = 0;
    end else begin
      automatic bit   acc = in_valid && (m_q.size() < 2);
      automatic bit   con = (m_q.size() > 0) && out_ready;
      automatic ent_t e = '{rdata1: in_rdata1, rdata2: in_rdata2, imm: in_imm,
                            alusrc: in_alusrc, rd: in_rd, ctrl: in_ctrl};
      if ((m_q.size() > 0) && !out_ready && !flush && (m_cnt < CNT_MAX)) m_cnt++;
      if (flush) begin
        m_q.delete();
      end else begin
        if (con) void'(m_q.pop_front());
        if (acc) m_q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", out_valid, m_q.size() > 0);
      chk("in_ready", in_ready, m_q.size() < 2);
      chk("stall_cnt", stall_cnt, m_cnt);
      if (m_q.size() > 0) begin
        chk("out_rd", out_rd, m_q[0].rd);
        chk("out_rdata1", out_rdata1, m_q[0].rdata1);
        chk("out_rdata2", out_rdata2, m_q[0].rdata2);
        chk("out_imm", out_imm, m_q[0].imm);
        chk("out_alusrc", out_alusrc, m_q[0].alusrc);
        chk("out_ctrl", out_ctrl, m_q[0].ctrl);
      end
      if (out_valid && out_ready) log_rd.push_back(int'(out_rd));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rd);
    in_valid  = v;
    in_rd     = rd;
    in_rdata1 = 32'h1000_0000 | 32'(rd);
    in_rdata2 = 32'hABCD_0000 | 32'(rd);
    in_imm    = -32'(rd);
    in_alusrc = rd[0];
    in_ctrl   = 8'(rd) * 8'd7;
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_len"}, log_rd.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_rd.size(); i++)
      chk(name, log_rd[i], exp[i]);
  endtask

  initial begin
    // Reset with decode already offering an entry.
    drive(1'b1, 5'd9);
    step(3);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_imm", out_imm, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    step(1);

    // First entry, one cycle latency.
    in_valid = 1'b1; in_rdata1 = 32'h11; in_rdata2 = 32'h22;
    in_imm = 32'hFFFF_FFF0; in_alusrc = 1'b1; in_rd = 5'd5; in_ctrl = 8'hA5;
    step(1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("first_valid", out_valid, 1);
    chk("first_rdata1", out_rdata1, 32'h11);
    chk("first_imm", out_imm, 32'hFFFF_FFF0);
    chk("first_alusrc", out_alusrc, 1);
    chk("first_rd", out_rd, 5);
    chk("first_ctrl", out_ctrl, 8'hA5);
    step(2);

    // Streaming at full rate.
    log_rd.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 5'(i));
      step(1);
    end
    drive(1'b0, 5'd0);
    step(2);
    chk_log("stream_rd", '{1, 2, 3, 4, 5, 6, 7, 8});
    chk("stream_stall", stall_cnt, 0);

    // Skid fill under backpressure.
    log_rd.delete();
    out_ready = 1'b0;
    drive(1'b1, 5'd1); step(1);
    drive(1'b1, 5'd2); step(1);
    drive(1'b1, 5'd3); step(1);
    @(negedge clk);
    chk("skid_in_ready", in_ready, 0);
    chk("skid_out_rd", out_rd, 1);
    chk("skid_stall2", stall_cnt, 2);
    step(2);
    @(negedge clk);
    chk("skid_hold_rd", out_rd, 1);
    chk("skid_stall4", stall_cnt, 4);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(2);
    drive(1'b0, 5'd0);
    step(2);
    chk_log("skid_drain_rd", '{1, 2, 3});

    // Flush from TWO with an incoming entry.
    log_rd.delete();
    out_ready = 1'b0;
    drive(1'b1, 5'd4); step(1);
    drive(1'b1, 5'd5); step(1);
    drive(1'b1, 5'd6); flush = 1'b1;
    step(1);
    flush = 1'b0; drive(1'b0, 5'd0);
    @(negedge clk);
    chk("flush2_out_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    step(3);
    chk("flush2_no_output", log_rd.size(), 0);

    // Flush from ONE while an entry is accepted: that entry is discarded too.
    out_ready = 1'b0;
    drive(1'b1, 5'd7); step(1);
    drive(1'b1, 5'd8); flush = 1'b1;
    step(1);
    flush = 1'b0; drive(1'b0, 5'd0);
    out_ready = 1'b1;
    step(3);
    chk("flush1_no_output", log_rd.size(), 0);

    // Counter saturation after a fresh reset.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 5'd10); step(1);
    drive(1'b0, 5'd0);
    step(20);
    @(negedge clk);
    chk("sat_stall_cnt", stall_cnt, CNT_MAX);
    chk("sat_out_rd", out_rd, 10);

    // Asynchronous reset between edges while in TWO.
    @(posedge clk); #1;
    drive(1'b1, 5'd11); step(1);
    drive(1'b0, 5'd0);
    @(negedge clk);
    chk("pre_arst_in_ready", in_ready, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_rd", out_rd, 0);
    step(2);
    rst = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
